dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and the 256-bit line-wide data memory.
- Serves 32-bit word loads and stores from the CPU.
- On a miss it stalls the pipeline, writes back a dirty victim line, refills the line from memory using the enable/write/ack handshake, then completes the access.

Parameters:
- NUM_LINES, 32, number of cache lines (power of two); IDX_W = log2(NUM_LINES).
- LINE_W, 256, line width in bits (32-byte line, 8 words).
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-high.
- p1_addr_i  in  32  CPU byte address.
- p1_data_i  in  32  CPU store data.
- p1_mem_read_i  in  1  CPU load request.
- p1_mem_write_i  in  1  CPU store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  pipeline stall.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line-aligned byte address; low 5 bits are 0.
- mem_data_o  out  256  write-back line.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse.
- hit_cnt_o  out  32  hit counter (see Optional Feature).
- miss_cnt_o  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2].
  - index = addr[5+IDX_W-1:5].
  - tag = addr[31:5+IDX_W] (22 bits at default).
- Per-line state: valid, dirty, tag, data.
- req = p1_mem_read_i | p1_mem_write_i.
- hit = valid[index] & (tag[index] == addr tag).
- p1_stall_o = req & ~(hit & state==IDLE). Combinational.
- p1_data_o = word select of the indexed line, combinational. Value is don't-care unless a read hit.
- Read hit: zero added latency, no stall.
- Write hit: on posedge, merge p1_data_i into the selected word and set dirty=1. Other words are unchanged.
- State machine (package enum) has states IDLE, WRITEBACK, WB_GAP, ALLOCATE, REFILL.
  - IDLE: on req & ~hit:
    - If the victim is valid & dirty, go to WRITEBACK.
    - Otherwise go to ALLOCATE.
  - WRITEBACK:
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
    - Stays until mem_ack_i=1.
    - On the ack edge: mem_enable_o←0, go to WB_GAP.
  - WB_GAP: one cycle with mem_enable_o=0, so memory returns to idle. Then go to ALLOCATE.
  - ALLOCATE:
    - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 5'b0}.
    - On mem_ack_i: latch mem_data_i, mem_enable_o←0, go to REFILL.
  - REFILL: write the line with valid=1, dirty=0 and the new tag. Go to IDLE.
  - Back in IDLE the access now hits and completes. A store merges in that cycle.
- Memory-side outputs are registered. mem_enable_o stays asserted continuously from state entry until the ack is sampled. mem_addr_o and mem_data_o are stable for the whole request.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- If the CPU request drops mid-miss, the in-flight memory transaction still completes. The FSM then returns to IDLE with no store merge.
- Simultaneous read & write requests are illegal; write takes priority.
- Reset:
  - Applies at any state, including mid-transaction.
  - state←IDLE, all valid←0, dirty←0, mem_enable_o←0, mem_write_o←0, mem_addr_o←0, mem_data_o←0, counters←0.
  - p1_stall_o follows req (every request misses after reset).
  - Data and tag arrays are not reset.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments once per completed access that hit on first presentation in IDLE.
  - miss_cnt_o increments once per IDLE→miss transition.
  - Both wrap at 2^32.
- Undefined: counters are not instantiated; hit_cnt_o and miss_cnt_o are tied to 0.

Decomposition:
- Package dcache_pkg holds:
  - FSM state enum.
  - OFFSET_W=5, WORD_SEL_W=3, tag/index width functions of NUM_LINES.
  - Line and tag typedefs.
- Sub-module dcache_sram: tag/valid/dirty/data arrays, with asynchronous read and a synchronous write port (full line or word-merge with byte-enable per 32-bit word).

Test Plan:
- Cold read after reset:
  - Stimulus: read 0x0000_0040.
  - Response: stall; ALLOCATE with mem_addr_o=0x40, write=0; stall drops in the cycle after REFILL; p1_data_o = word 0 of the returned line; miss_cnt=1.
- Read hit:
  - Stimulus: read 0x44 next.
  - Response: no stall; word 1 is returned the same cycle; hit_cnt=1.
- Write hit then dirty eviction:
  - Stimulus: store 0xDEADBEEF at 0x48, then read 0x0000_0440 (same index, new tag).
  - Response: WRITEBACK to 0x40 with word 2 = 0xDEADBEEF; one WB_GAP cycle with enable low; then ALLOCATE at 0x440.
- Clean eviction:
  - Stimulus: read 0x0000_0840 (same index, line clean).
  - Response: no WRITEBACK; direct ALLOCATE.
- Handshake hold:
  - Stimulus: delay mem_ack_i 7 cycles.
  - Response: mem_enable_o, mem_addr_o and mem_data_o are held stable throughout; enable drops on the ack edge.
- Reset mid-ALLOCATE:
  - Stimulus: assert rst_i during ALLOCATE.
  - Response: mem_enable_o=0 next cycle; state IDLE; a subsequent read of the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        WB_GAP,
        ALLOCATE,
        REFILL
    } state_e;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - OFFSET_W - $clog2(num_lines);
    endfunction

    typedef logic [255:0]               line_t;
    typedef logic [tag_w(32, 32)-1:0]   tag_t;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and line-memory-side signals of the data cache; slave is the cache itself.
interface dcache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_mem_read_i;
    logic              p1_mem_write_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_mem_read_i, p1_mem_write_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_mem_read_i, p1_mem_write_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, one synchronous write port with per-word enables.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 32,
    parameter  int LINE_W    = 256,
    parameter  int TAG_W     = 22,
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int WORDS     = LINE_W / WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORDS-1:0]  wr_be_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              wr_dirty_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int w = 0; w < WORDS; w++)
                if (wr_be_i[w]) data_q[wr_idx_i][w*WORD_W +: WORD_W] <= wr_data_i[w*WORD_W +: WORD_W];
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// DCACHE_STATS_EN adds the hit/miss counters; otherwise they read as zero.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  bus,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);
    localparam int WORDS = LINE_W / WORD_W;

    state_e             state_q, state_d;
    logic               men_q, men_d, mwr_q, mwr_d;
    logic [ADDR_W-1:0]  maddr_q, maddr_d;
    logic [LINE_W-1:0]  mdata_q, mdata_d, fill_q, fill_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;

    logic               req, hit, rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag, cpu_tag;
    logic [IDX_W-1:0]   cpu_idx;
    logic [WORD_SEL_W-1:0] wsel;
    logic [LINE_W-1:0]  rd_data;
    logic               sram_we, sram_dirty;
    logic [IDX_W-1:0]   sram_idx;
    logic [WORDS-1:0]   sram_be;
    logic [TAG_W-1:0]   sram_tag;
    logic [LINE_W-1:0]  sram_data;
    logic               unused_addr_bits;

    assign cpu_idx = bus.p1_addr_i[OFFSET_W +: IDX_W];
    assign cpu_tag = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel    = bus.p1_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_bits = ^bus.p1_addr_i[1:0];

    assign req            = bus.p1_mem_read_i | bus.p1_mem_write_i;
    assign hit            = rd_valid & (rd_tag == cpu_tag);
    assign bus.p1_stall_o = req & ~(hit & (state_q == IDLE));
    assign bus.p1_data_o  = rd_data[wsel*WORD_W +: WORD_W];

    assign bus.mem_enable_o = men_q;
    assign bus.mem_write_o  = mwr_q;
    assign bus.mem_addr_o   = maddr_q;
    assign bus.mem_data_o   = mdata_q;

    dcache_sram #(.NUM_LINES(NUM_LINES), .LINE_W(LINE_W), .TAG_W(TAG_W)) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (cpu_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (sram_we),
        .wr_idx_i   (sram_idx),
        .wr_be_i    (sram_be),
        .wr_tag_i   (sram_tag),
        .wr_data_i  (sram_data),
        .wr_dirty_i (sram_dirty)
    );

    // Refill uses the latched miss address so a dropped CPU request cannot corrupt the fill.
    always_comb begin
        sram_we    = 1'b0;
        sram_idx   = cpu_idx;
        sram_be    = '0;
        sram_tag   = cpu_tag;
        sram_data  = {WORDS{bus.p1_data_i}};
        sram_dirty = 1'b1;
        if (state_q == REFILL) begin
            sram_we    = 1'b1;
            sram_idx   = miss_idx_q;
            sram_be    = '1;
            sram_tag   = miss_tag_q;
            sram_data  = fill_q;
            sram_dirty = 1'b0;
        end else if (state_q == IDLE && bus.p1_mem_write_i && hit) begin
            sram_we = 1'b1;
            sram_be = WORDS'(1) << wsel;
        end
    end

    always_comb begin
        state_d    = state_q;
        men_d      = men_q;
        mwr_d      = mwr_q;
        maddr_d    = maddr_q;
        mdata_d    = mdata_q;
        fill_d     = fill_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        case (state_q)
            IDLE: if (req && !hit) begin
                miss_tag_d = cpu_tag;
                miss_idx_d = cpu_idx;
                men_d      = 1'b1;
                if (rd_valid && rd_dirty) begin
                    state_d = WRITEBACK;
                    mwr_d   = 1'b1;
                    maddr_d = {rd_tag, cpu_idx, {OFFSET_W{1'b0}}};
                    mdata_d = rd_data;
                end else begin
                    state_d = ALLOCATE;
                    mwr_d   = 1'b0;
                    maddr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
                end
            end
            WRITEBACK: if (bus.mem_ack_i) begin
                men_d   = 1'b0;
                mwr_d   = 1'b0;
                state_d = WB_GAP;
            end
            WB_GAP: begin
                men_d   = 1'b1;
                mwr_d   = 1'b0;
                maddr_d = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
                state_d = ALLOCATE;
            end
            ALLOCATE: if (bus.mem_ack_i) begin
                men_d   = 1'b0;
                fill_d  = bus.mem_data_i;
                state_d = REFILL;
            end
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            men_q      <= 1'b0;
            mwr_q      <= 1'b0;
            maddr_q    <= '0;
            mdata_q    <= '0;
            fill_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            men_q      <= men_d;
            mwr_q      <= mwr_d;
            maddr_q    <= maddr_d;
            mdata_q    <= mdata_d;
            fill_q     <= fill_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        post_fill_q;

    // The cycle right after REFILL completes a miss, so it must not count as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            post_fill_q <= 1'b0;
        end else begin
            post_fill_q <= (state_q == REFILL);
            if (state_q == IDLE && req && hit && !post_fill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule
